alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//   Instruction issue/writeback sequencer that drives the 16-bit ALU.
//   Holds an 8x16 register file, decodes one instruction per handshake, and presents
//   operator/operands to the ALU. Captures the ALU's registered result one cycle later
//   and writes it back to the destination register. Sits between the instruction source
//   and the ALU; it is the initiator side of the ALU operator/op1/op2/op3 interface.
// PARAMETERS
//   NUM_BITS   16  datapath width (regfile, ALU operands/result)
//   OP_BITS     3  ALU operator width
//   REG_ADDR    3  register address width (2**REG_ADDR registers)
// PORTS
//   clk          in   1         clock, rising edge
//   rst          in   1         reset, asynchronous, active-low
//   instr_valid  in   1         instruction offered
//   instr_ready  out  1         block can accept an instruction
//   instr        in   16        [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored
//   wr_en        in   1         external regfile write (init/load)
//   wr_addr      in   3         external write address
//   wr_data      in   16        external write data
//   rd_addr      in   3         debug read address
//   rd_data      out  16        regfile[rd_addr], combinational
//   alu_op       out  3         ALU operator (0 ADD,1 SUB,2 MULT,3 NAND,4 DIV,5 MOD,6 ROTL,7 NOP)
//   alu_a        out  16        ALU operand 1 (regfile[rs1])
//   alu_b        out  16        ALU operand 2 (regfile[rs2])
//   alu_result   in   16        ALU registered result
//   done         out  1         one-cycle pulse: instruction retired
//   err          out  1         valid with done: 1 = DIV/MOD by zero, no writeback
//   result       out  16        value written back (0 when err), held until next done
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; all regfile entries 0; alu_op=7 (NOP); alu_a=alu_b=0;
//     done=0; err=0; result=0. instr_ready=0 while rst=0.
//   FSM: IDLE -> ISSUE -> WB -> IDLE. instr_ready = (state==IDLE) && !wr_en.
//   IDLE: edge with instr_valid && instr_ready latches opcode/rd; alu_op, alu_a, alu_b
//     are registered from regfile[rs1]/regfile[rs2] at the same edge; -> ISSUE.
//   Operator outputs only change on that accepting edge and return to NOP/0/0 on the
//     edge leaving ISSUE; they are stable for the whole ISSUE cycle.
//   ISSUE: ALU samples operator/operands at end of this cycle; -> WB.
//   WB: alu_result valid; at the edge leaving WB: regfile[rd] <= alu_result,
//     result <= alu_result, done <= 1, err <= 0; -> IDLE.
//   Divide-by-zero: opcode 4 or 5 with regfile[rs2]==0 at acceptance: alu_op driven as 7
//     (NOP) instead, sequence timing unchanged, WB does not write regfile; result <= 0,
//     done <= 1, err <= 1.
//   done/err are 1-cycle pulses (cycle after WB edge); cleared on the following edge.
//   Latency: accept edge E0 -> writeback + done edge E2 (done high in cycle after E2).
//     Throughput: one instruction per 3 cycles; instr_ready high again in cycle after E2.
//   Read-after-write: writeback completes before next acceptance, so a following
//     instruction reading the previous rd sees the new value; no forwarding needed.
//   External write: performed at the edge only when state==IDLE and wr_en=1; has priority
//     over instruction acceptance (instr_ready=0 that cycle). wr_en outside IDLE is dropped.
//   Arithmetic: all values NUM_BITS wide; ALU wrap/truncation accepted as-is, no flags.
//   rd == rs1/rs2 allowed; operands are read at acceptance, so no hazard.
//   Reset mid-operation (ISSUE or WB): in-flight instruction abandoned, no writeback, no
//     done; all state returns to reset values immediately.
//   instr_valid held with instr_ready=0: no effect; instr may change freely until accepted.
// TESTING
//   Reset then read r0..r7 via rd_addr -> all 0x0000; alu_op=7, done=0, instr_ready=1.
//   Write r1=0x0003, r2=0x0005; ADD r3=r1+r2 -> alu_op=0 in ISSUE, done 3 cycles after
//     accept, result=0x0008, rd_data(r3)=0x0008, err=0.
//   r1=0x0000, r2=0x0001; SUB r4=r1-r2 -> result=0xFFFF (wrap), r4=0xFFFF.
//   r5=0x0000; DIV r6=r1/r5 with r6 preloaded 0x1234 -> alu_op=7, done=1, err=1,
//     result=0, r6 stays 0x1234.
//   Back-to-back: ADD r1=r1+r2 then ADD r1=r1+r2 with valid held high -> second accept
//     3 cycles after first; r1 = 0x0003+2*0x0005 = 0x000D.
//   Accept MULT, assert rst in WB -> no write to rd, done stays 0, all outputs at reset
//     values; wr_en during ISSUE -> write dropped.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl_if
// Brief   : Instruction, register-file access and ALU operator bus of the
//           ALU issue/writeback sequencer.
// Revision: 1.0
// ============================================================================
interface alu_issue_ctrl_if #(
    parameter int NUM_BITS = 16,
    parameter int OP_BITS  = 3,
    parameter int REG_ADDR = 3
) ();
    logic                instr_valid;
    logic                instr_ready;
    logic [NUM_BITS-1:0] instr;
    logic                wr_en;
    logic [REG_ADDR-1:0] wr_addr;
    logic [NUM_BITS-1:0] wr_data;
    logic [REG_ADDR-1:0] rd_addr;
    logic [NUM_BITS-1:0] rd_data;
    logic [OP_BITS-1:0]  alu_op;
    logic [NUM_BITS-1:0] alu_a;
    logic [NUM_BITS-1:0] alu_b;
    logic [NUM_BITS-1:0] alu_result;
    logic                done;
    logic                err;
    logic [NUM_BITS-1:0] result;

    // Sequencer side
    modport slave (
        input  instr_valid, instr, wr_en, wr_addr, wr_data, rd_addr, alu_result,
        output instr_ready, rd_data, alu_op, alu_a, alu_b, done, err, result
    );

    // Instruction source / ALU side
    modport master (
        output instr_valid, instr, wr_en, wr_addr, wr_data, rd_addr, alu_result,
        input  instr_ready, rd_data, alu_op, alu_a, alu_b, done, err, result
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Brief   : 8x16 register file plus IDLE/ISSUE/WB sequencer that issues one
//           instruction to a registered ALU and writes its result back.
// Revision: 1.0
// ============================================================================
module alu_issue_ctrl #(
    parameter int NUM_BITS = 16,
    parameter int OP_BITS  = 3,
    parameter int REG_ADDR = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    alu_issue_ctrl_if.slave   bus
);
    localparam int                 c_NUM_REGS = 1 << REG_ADDR;
    localparam logic [OP_BITS-1:0] c_OP_DIV   = OP_BITS'(4);
    localparam logic [OP_BITS-1:0] c_OP_MOD   = OP_BITS'(5);
    localparam logic [OP_BITS-1:0] c_OP_NOP   = {OP_BITS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NUM_BITS-1:0] r_regs [c_NUM_REGS];
    logic [REG_ADDR-1:0] r_rd;
    logic                r_div0;
    logic [OP_BITS-1:0]  r_alu_op;
    logic [NUM_BITS-1:0] r_alu_a;
    logic [NUM_BITS-1:0] r_alu_b;
    logic                r_done;
    logic                r_err;
    logic [NUM_BITS-1:0] r_result;

    logic [OP_BITS-1:0]  w_opcode;
    logic [REG_ADDR-1:0] w_rd;
    logic [REG_ADDR-1:0] w_rs1;
    logic [REG_ADDR-1:0] w_rs2;
    logic                w_instr_ready;
    logic                w_accept;
    logic                w_div0;
    logic                w_unused_instr;

    assign w_opcode       = bus.instr[15:13];
    assign w_rd           = bus.instr[12:10];
    assign w_rs1          = bus.instr[9:7];
    assign w_rs2          = bus.instr[6:4];
    assign w_unused_instr = ^bus.instr[3:0];

    // External writes win over acceptance; nothing is accepted while in reset.
    assign w_instr_ready = rst && (r_state == S_IDLE) && !bus.wr_en;
    assign w_accept      = bus.instr_valid && w_instr_ready;
    assign w_div0        = ((w_opcode == c_OP_DIV) || (w_opcode == c_OP_MOD)) &&
                           (r_regs[w_rs2] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_rd     <= '0;
            r_div0   <= 1'b0;
            r_alu_op <= c_OP_NOP;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.wr_en) begin
                        r_regs[bus.wr_addr] <= bus.wr_data;
                    end else if (w_accept) begin
                        r_rd     <= w_rd;
                        r_div0   <= w_div0;
                        // A zero divisor is never shown to the ALU.
                        r_alu_op <= w_div0 ? c_OP_NOP : w_opcode;
                        r_alu_a  <= r_regs[w_rs1];
                        r_alu_b  <= r_regs[w_rs2];
                    end
                end
                S_ISSUE: begin
                    r_alu_op <= c_OP_NOP;
                    r_alu_a  <= '0;
                    r_alu_b  <= '0;
                end
                S_WB: begin
                    r_done <= 1'b1;
                    if (r_div0) begin
                        r_err    <= 1'b1;
                        r_result <= '0;
                    end else begin
                        r_regs[r_rd] <= bus.alu_result;
                        r_result     <= bus.alu_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready = w_instr_ready;
    assign bus.rd_data     = r_regs[bus.rd_addr];
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.result      = r_result;
endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue_ctrl
// Brief   : Directed bench for alu_issue_ctrl with a registered ALU model and
//           a retirement scoreboard.
// Revision: 1.0
// ============================================================================
module tb_alu_issue_ctrl;
    localparam int NUM_BITS = 16;
    localparam int OP_BITS  = 3;
    localparam int REG_ADDR = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.NUM_BITS(NUM_BITS), .OP_BITS(OP_BITS), .REG_ADDR(REG_ADDR)) bus ();

    alu_issue_ctrl #(.NUM_BITS(NUM_BITS), .OP_BITS(OP_BITS), .REG_ADDR(REG_ADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [16:0] sb_q [$];
    logic [16:0] mon_exp;

    // Registered 16-bit ALU: samples operator/operands at the end of ISSUE.
    function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        logic [31:0] prod;
        logic [3:0]  sh;
        prod = a * b;
        sh   = b[3:0];
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return prod[15:0];
            3'd3:    return ~(a & b);
            3'd4:    return (b == 16'h0) ? 16'h0 : a / b;
            3'd5:    return (b == 16'h0) ? 16'h0 : a % b;
            3'd6:    return (a << sh) | (a >> (5'd16 - {1'b0, sh}));
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) bus.alu_result <= '0;
        else      bus.alu_result <= alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout, expected event within bound", name);
    endtask

    // Retirement monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.done === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got err=%0b result=0x%0h, expected no retirement",
                         bus.err, bus.result);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({bus.err, bus.result} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL retire: got err=%0b result=0x%0h, expected err=%0b result=0x%0h",
                             bus.err, bus.result, mon_exp[16], mon_exp[15:0]);
                end
            end
        end
    end

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [2:0] addr, input logic [15:0] exp);
        bus.rd_addr = addr;
        #1;
        check(name, 32'(bus.rd_data), 32'(exp));
    endtask

    // Offers one instruction, returns at the negedge of its ISSUE cycle.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic push, input logic [15:0] exp_res,
                         input logic exp_err, input logic [2:0] exp_aluop);
        int n;
        @(negedge clk);
        bus.instr       = {op, rd, rs1, rs2, 4'h0};
        bus.instr_valid = 1'b1;
        n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            fail_timeout("accept");
            bus.instr_valid = 1'b0;
            return;
        end
        if (push) sb_q.push_back({exp_err, exp_res});
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("alu_op_in_issue", 32'(bus.alu_op), 32'(exp_aluop));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) return;
        end
        fail_timeout("done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.rd_addr     = '0;
        repeat (2) @(negedge clk);
        check("ready_in_reset", 32'(bus.instr_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("reset_alu_op", 32'(bus.alu_op), 32'd7);
        check("reset_alu_a", 32'(bus.alu_a), 32'd0);
        check("reset_alu_b", 32'(bus.alu_b), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_result", 32'(bus.result), 32'd0);
        check("reset_ready", 32'(bus.instr_ready), 32'd1);
        for (int i = 0; i < 8; i++) read_chk("reset_reg", 3'(i), 16'h0000);

        // ADD r3 = r1 + r2 with cycle-accurate timing checks
        wr(3'd1, 16'h0003);
        wr(3'd2, 16'h0005);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b1, 16'h0008, 1'b0, 3'd0);
        check("add_alu_a", 32'(bus.alu_a), 32'h3);
        check("add_alu_b", 32'(bus.alu_b), 32'h5);
        @(negedge clk);
        check("add_done_in_wb", 32'(bus.done), 32'd0);
        check("add_op_back_to_nop", 32'(bus.alu_op), 32'd7);
        @(negedge clk);
        check("add_done_pulse", 32'(bus.done), 32'd1);
        read_chk("add_r3", 3'd3, 16'h0008);
        @(negedge clk);
        check("add_done_cleared", 32'(bus.done), 32'd0);

        // SUB wraps
        wr(3'd1, 16'h0000);
        wr(3'd2, 16'h0001);
        issue(3'd1, 3'd4, 3'd1, 3'd2, 1'b1, 16'hFFFF, 1'b0, 3'd1);
        wait_done();
        read_chk("sub_r4", 3'd4, 16'hFFFF);

        // DIV by zero: NOP issued, err, no writeback
        wr(3'd5, 16'h0000);
        wr(3'd6, 16'h1234);
        issue(3'd4, 3'd6, 3'd1, 3'd5, 1'b1, 16'h0000, 1'b1, 3'd7);
        wait_done();
        read_chk("div0_r6_kept", 3'd6, 16'h1234);

        // Back-to-back ADD r1 = r1 + r2 with valid held high
        wr(3'd1, 16'h0003);
        wr(3'd2, 16'h0005);
        @(negedge clk);
        bus.instr       = {3'd0, 3'd1, 3'd1, 3'd2, 4'h0};
        bus.instr_valid = 1'b1;
        #1;
        check("b2b_first_ready", 32'(bus.instr_ready), 32'd1);
        sb_q.push_back({1'b0, 16'h0008});
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("b2b_ready_gap", 32'(bus.instr_ready), (k == 3) ? 32'd1 : 32'd0);
        end
        sb_q.push_back({1'b0, 16'h000D});
        @(negedge clk);
        bus.instr_valid = 1'b0;
        wait_done();
        read_chk("b2b_r1", 3'd1, 16'h000D);

        // MULT with an external write attempted during ISSUE (dropped)
        issue(3'd2, 3'd7, 3'd1, 3'd2, 1'b1, 16'h0041, 1'b0, 3'd2);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = 16'hBEEF;
        #1;
        check("ready_busy", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_done();
        read_chk("wr_dropped_r0", 3'd0, 16'h0000);
        read_chk("mult_r7", 3'd7, 16'h0041);

        // MULT abandoned by reset during WB
        issue(3'd2, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0, 3'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wb_done", 32'(bus.done), 32'd0);
        check("rst_wb_alu_op", 32'(bus.alu_op), 32'd7);
        check("rst_wb_result", 32'(bus.result), 32'd0);
        check("rst_wb_ready", 32'(bus.instr_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_wb_no_done", 32'(bus.done), 32'd0);
        end
        rst = 1'b1;
        read_chk("rst_wb_r5", 3'd5, 16'h0000);
        read_chk("rst_wb_r7", 3'd7, 16'h0000);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
